instr_fetch_unit: RTL and testbench

//  Owns the architectural PC register and consumes the next-PC chosen by the PC select mux.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_out_buf.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

    // PC select mux encodings
    localparam logic [2:0] INC4   = 3'b000;
    localparam logic [2:0] BRANCH = 3'b001;
    localparam logic [2:0] JALR   = 3'b100;
    localparam logic [2:0] JAL    = 3'b110;

    // True when the PC select encoding replaces the sequential PC
    function automatic logic sel_is_redirect(input logic [2:0] sel);
        return (sel == BRANCH) || (sel == JALR) || (sel == JAL);
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Output buffer towards decode: holds if_valid/if_pc/if_pc_plus4/if_instr.
// Load has priority over the handshake; flush has priority over everything.
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [ADDR_W-1:0]  load_pc_i,
    input  logic [INSTR_W-1:0] load_instr_i,
    input  logic               flush_i,
    input  logic               if_ready_i,
    output logic               fire_o,
    output logic               if_valid_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic [ADDR_W-1:0]  if_pc_plus4_o,
    output logic [INSTR_W-1:0] if_instr_o
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    assign fire_o = valid_q && if_ready_i;

    // Next-state: flush, load, or retire on handshake
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = load_pc_i;
            pc4_d   = load_pc_i + ADDR_W'(PC_INC);
            instr_d = load_instr_i;
        end else if (fire_o) begin
            valid_d = 1'b0;
        end
    end

    // Buffer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    assign if_valid_o    = valid_q;
    assign if_pc_o       = pc_q;
    assign if_pc_plus4_o = pc4_q;
    assign if_instr_o    = instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding imem req/gnt/rvalid
// fetch FSM and decode-side valid/ready buffer. Redirects cancel in-flight work.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned      INSTR_W  = 32
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_killed
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] redir_pc;
    logic              buf_load, buf_flush, if_fire, killed;

    assign redir_pc  = redirect_pc & ~ADDR_W'(3);
    assign imem_req  = (state_q == S_REQ) && !redirect_valid;
    assign imem_addr = pc_q & ~ADDR_W'(3);

    // Next-state for FSM and PC; redirect always beats sequential increment
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        killed    = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end else if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(PC_INC);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_rvalid) begin
                        killed  = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem_rvalid) begin
                    buf_load = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                // The stale response still has to be absorbed before a new request
                if (imem_rvalid) begin
                    killed  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d      = redir_pc;
                    buf_flush = 1'b1;
                    killed    = !if_fire;
                    state_d   = S_REQ;
                end else if (if_fire) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // FSM and PC registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_out_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_out_buf (
        .clk_i         (CLK),
        .rst_ni        (RSTn),
        .load_i        (buf_load),
        .load_pc_i     (req_pc_q),
        .load_instr_i  (imem_rdata),
        .flush_i       (buf_flush),
        .if_ready_i    (if_ready),
        .fire_o        (if_fire),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_pc_plus4_o (if_pc_plus4),
        .if_instr_o    (if_instr)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] killed_q, killed_d;

    // Saturating event counters
    always_comb begin
        fetched_d = fetched_q;
        killed_d  = killed_q;
        if (if_fire && (fetched_q != 32'hFFFF_FFFF)) begin
            fetched_d = fetched_q + 32'd1;
        end
        if (killed && (killed_q != 32'hFFFF_FFFF)) begin
            killed_d = killed_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetched_q <= '0;
            killed_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            killed_q  <= killed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_killed  = killed_q;
`endif

    // A response is only legal while one is outstanding
    rvalid_legal_a: assert property (@(posedge CLK) disable iff (!RSTn)
        imem_rvalid |-> ((state_q == S_WAIT) || (state_q == S_DROP)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a pc/instr scoreboard.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [11:0] if_pc;
    logic [11:0] if_pc_plus4;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [43:0] sb[$];

    always #5 CLK = ~CLK;

    instr_fetch_unit #(
        .ADDR_W   (12),
        .RESET_PC (12'h000),
        .INSTR_W  (32)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_killed    (perf_killed)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One full fetch: grant at addr, rvalid next cycle, hold 'hold' cycles, then accept
    task automatic fetch_one(input logic [11:0] addr, input logic [31:0] data, input int hold);
        logic [43:0] e;
        logic [11:0] e_pc4;
        imem_gnt = 1'b1;
        #1;
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", {20'd0, imem_addr}, {20'd0, addr});
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back({addr, data});
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("if_valid_set", {31'd0, if_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e     = sb.pop_front();
            e_pc4 = e[43:32] + 12'd4;
            for (int i = 0; i < hold; i++) begin
                if_ready = 1'b0;
                step();
                chk("hold_valid", {31'd0, if_valid}, 32'd1);
                chk("hold_pc", {20'd0, if_pc}, {20'd0, e[43:32]});
                chk("hold_instr", if_instr, e[31:0]);
                chk("hold_noreq", {31'd0, imem_req}, 32'd0);
            end
            if_ready = 1'b1;
            #1;
            chk("if_pc", {20'd0, if_pc}, {20'd0, e[43:32]});
            chk("if_pc_plus4", {20'd0, if_pc_plus4}, {20'd0, e_pc4});
            chk("if_instr", if_instr, e[31:0]);
        end
        step();
        if_ready = 1'b0;
        chk("if_valid_clr", {31'd0, if_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", {20'd0, if_pc}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_addr", {20'd0, imem_addr}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        step();

        // 1. Sequential fetch
        fetch_one(12'h000, 32'h1111_0000, 0);
        fetch_one(12'h004, 32'h2222_0004, 0);
        fetch_one(12'h008, 32'h3333_0008, 0);

        // 2. Backpressure for 5 cycles
        fetch_one(12'h00C, 32'h4444_000C, 5);

        // 3. Redirect in S_WAIT, late stale response
        imem_gnt = 1'b1;
        #1;
        chk("t3_addr", {20'd0, imem_addr}, 32'h010);
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h100;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("t3_drop_valid", {31'd0, if_valid}, 32'd0);
        chk("t3_drop_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("t3_no_valid", {31'd0, if_valid}, 32'd0);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        fetch_one(12'h100, 32'h5555_0100, 0);

        // 4. Redirect in S_REQ with gnt high
        redirect_valid = 1'b1;
        redirect_pc    = 12'h043;
        imem_gnt       = 1'b1;
        #1;
        chk("t4_req_supp", {31'd0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        #1;
        chk("t4_addr", {20'd0, imem_addr}, 32'h040);
        fetch_one(12'h040, 32'h6666_0040, 0);

        // 5. Wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFC;
        step();
        redirect_valid = 1'b0;
        fetch_one(12'hFFC, 32'h7777_0FFC, 0);
        chk("t5_wrap_addr", {20'd0, imem_addr}, 32'h000);

`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd7);
        chk("perf_killed", perf_killed, 32'd1);
`endif

        // 6. Reset in S_WAIT
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        chk("t6_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_pc", {20'd0, if_pc}, 32'd0);
        chk("t6_pc4", {20'd0, if_pc_plus4}, 32'd0);
        chk("t6_instr", if_instr, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", {20'd0, imem_addr}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetched", perf_fetched, 32'd0);
        chk("t6_perf_killed", perf_killed, 32'd0);
`endif
        @(negedge CLK);
        RSTn = 1'b1;
        step();
        fetch_one(12'h000, 32'h8888_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
